// File: rtl/instr_prefetch_unit_pkg.sv
// Shared fetch-path types and constants for the instruction prefetch unit.
package instr_prefetch_unit_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(INSTR_BYTES - 1);
    endfunction

endpackage

// File: rtl/instr_prefetch_unit_if.sv
// Redirect, instruction-memory and decode-side handshake signals of the prefetch unit.
interface instr_prefetch_unit_if;
    import instr_prefetch_unit_pkg::*;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            instr_valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic            instr_ready;

    modport master (
        input  redirect_valid, redirect_pc,
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output instr_valid, instr, instr_pc,
        input  instr_ready
    );

    modport slave (
        output redirect_valid, redirect_pc,
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  instr_valid, instr, instr_pc,
        output instr_ready
    );

endinterface

// File: rtl/instr_prefetch_unit_fifo.sv
// Synchronous show-ahead FIFO of fetch entries; flush empties it in one cycle.
module instr_prefetch_unit_fifo
    import instr_prefetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  fetch_entry_t               push_data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output fetch_entry_t               head_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    fetch_entry_t  mem_q [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: pointers alone define which slots are live.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

    assign count_o = wr_ptr_q - rd_ptr_q;
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/instr_prefetch_unit.sv
// In-order instruction prefetcher: credit-limited word fetches, response queue, redirect flush.
module instr_prefetch_unit
    import instr_prefetch_unit_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_VECTOR
) (
    input logic                   clk,
    input logic                   rst,
    instr_prefetch_unit_if.master bus
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    // Doomed responses can pile on top of a full set of live ones.
    localparam int unsigned OW = CW + 1;
    localparam logic [OW:0] DepthLim = (OW + 1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [OW-1:0]   outstanding_q, outstanding_d;
    logic [OW-1:0]   discard_q, discard_d;
    logic [CW-1:0]   count;
    logic [OW:0]     credits_used;
    logic            issue, resp, push, pop;
    fetch_entry_t    head, push_entry;

    assign credits_used = (OW + 1)'(count) + {1'b0, outstanding_q} - {1'b0, discard_q};

    // Saturation guard only matters if memory stalls responses across repeated redirects.
    assign bus.imem_req  = !rst && (credits_used < DepthLim) && (outstanding_q != '1);
    assign bus.imem_addr = fetch_pc_q;

    assign issue = bus.imem_req && bus.imem_gnt;
    assign resp  = bus.imem_rvalid && (outstanding_q != '0);
    assign pop   = bus.instr_valid && bus.instr_ready;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        discard_d     = discard_q;
        push          = 1'b0;
        outstanding_d = outstanding_q + OW'(issue) - OW'(resp);
        if (bus.redirect_valid) begin
            fetch_pc_d = word_align(bus.redirect_pc);
            resp_pc_d  = word_align(bus.redirect_pc);
            discard_d  = outstanding_d;
        end else begin
            if (issue) fetch_pc_d = fetch_pc_q + XLEN'(INSTR_BYTES);
            if (resp) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - OW'(1);
                end else begin
                    push      = 1'b1;
                    resp_pc_d = resp_pc_q + XLEN'(INSTR_BYTES);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    assign push_entry = '{pc: resp_pc_q, instr: bus.imem_rdata};

    instr_prefetch_unit_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .rst_i       (rst),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .flush_i     (bus.redirect_valid),
        .head_o      (head),
        .count_o     (count)
    );

    assign bus.instr_valid = !rst && (count != '0);
    assign bus.instr       = bus.instr_valid ? head.instr : '0;
    assign bus.instr_pc    = bus.instr_valid ? head.pc : '0;

    rvalid_needs_outstanding_a: assert property (@(posedge clk) disable iff (rst)
        bus.imem_rvalid |-> outstanding_q != '0);

    no_overflow_a: assert property (@(posedge clk) disable iff (rst)
        push |-> (OW + 1)'(count) < DepthLim);

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Self-checking bench: cycle table after reset, memory model with scoreboard, corner sequences.
module tb_instr_prefetch_unit;
    import instr_prefetch_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_prefetch_unit_if bus ();

    instr_prefetch_unit #(
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_req_t;

    typedef struct {
        logic        rst;
        logic        ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    mem_req_t     pending[$];
    fetch_entry_t exp_q[$];
    logic [31:0]  m_pc = 32'h0;
    int checks = 0, errors = 0, cyc = 0, issue_cnt = 0, pop_cnt = 0;
    int lat_min = 1, lat_max = 1, gnt_pct = 100;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'hC0DE_F00D;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory model and scoreboard: runs 1 time unit after each negedge, after stimulus settles.
    always begin
        @(negedge clk);
        #1;
        cyc++;
        if (rst) begin
            pending.delete();
            exp_q.delete();
            m_pc = 32'h0;
            issue_cnt = 0;
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = '0;
            bus.imem_gnt    = 1'b0;
        end else begin
            if (pending.size() > 0 && pending[0].due <= cyc) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = data_of(pending[0].addr);
                void'(pending.pop_front());
            end else begin
                bus.imem_rvalid = 1'b0;
                bus.imem_rdata  = '0;
            end
            bus.imem_gnt = ($urandom_range(99) < gnt_pct);
            if (bus.imem_req && bus.imem_gnt) begin
                check("issue_addr", bus.imem_addr, m_pc);
                pending.push_back('{addr: bus.imem_addr, due: cyc + $urandom_range(lat_max, lat_min)});
                exp_q.push_back('{pc: m_pc, instr: data_of(m_pc)});
                m_pc += 32'd4;
                issue_cnt++;
            end
            if (bus.instr_valid && bus.instr_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: got pc %h expected no delivery", bus.instr_pc);
                end else begin
                    fetch_entry_t e;
                    e = exp_q.pop_front();
                    check("pop_pc", bus.instr_pc, e.pc);
                    check("pop_instr", bus.instr, e.instr);
                    pop_cnt++;
                end
            end
            if (bus.redirect_valid) begin
                exp_q.delete();
                m_pc = bus.redirect_pc & ~32'h3;
            end
        end
    end

    task automatic apply_reset(input int lmin, input int lmax, input int gp, input logic rdy);
        @(negedge clk);
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        lat_min = lmin;
        lat_max = lmax;
        gnt_pct = gp;
        @(negedge clk);
        rst = 1'b0;
        bus.instr_ready = rdy;
    endtask

    task automatic wait_valid(input string name, input int max_cyc);
        int n = 0;
        while (!bus.instr_valid && n < max_cyc) begin
            @(negedge clk);
            #2;
            n++;
        end
        checks++;
        if (!bus.instr_valid) begin
            errors++;
            $display("FAIL %s: instr_valid not seen within %0d cycles", name, max_cyc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        int   p0;
        bit   did_pop_redir;

        rst = 1'b1;
        bus.instr_ready    = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_gnt       = 1'b0;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = '0;

        // Reset state, then steady stream: gnt=1, latency 1, one stall cycle.
        vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 32'h14, 1'b1, 32'h0C};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 32'h18, 1'b1, 32'h0C};
        vecs[8] = '{1'b0, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            rst = vecs[i].rst;
            bus.instr_ready = vecs[i].ready;
            #2;
            check("tbl_req", bus.imem_req, vecs[i].exp_req);
            check("tbl_addr", bus.imem_addr, vecs[i].exp_addr);
            check("tbl_valid", bus.instr_valid, vecs[i].exp_valid);
            check("tbl_pc", bus.instr_pc, vecs[i].exp_pc);
            check("tbl_instr", bus.instr, vecs[i].exp_valid ? data_of(vecs[i].exp_pc) : 32'h0);
        end

        // Back-pressure: credits stop issue at 4, then the queue drains in order.
        apply_reset(1, 1, 100, 1'b0);
        repeat (10) @(negedge clk);
        #2;
        check("bp_issues", issue_cnt, 4);
        check("bp_req_low", bus.imem_req, 1'b0);
        check("bp_valid", bus.instr_valid, 1'b1);
        check("bp_head_pc", bus.instr_pc, 32'h0);
        @(negedge clk);
        p0 = pop_cnt;
        bus.instr_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check("bp_drain_pops", pop_cnt - p0, 4);

        // Redirect while two requests (0x8, 0xC) are still in flight.
        apply_reset(2, 2, 100, 1'b0);
        repeat (4) @(negedge clk);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #2;
        check("r2_flushed", bus.instr_valid, 1'b0);
        check("r2_req", bus.imem_req, 1'b1);
        check("r2_addr", bus.imem_addr, 32'h100);
        bus.instr_ready = 1'b1;
        wait_valid("r2_first_valid", 10);
        check("r2_first_pc", bus.instr_pc, 32'h100);

        // Redirect colliding with grant, rvalid and pop; misaligned target.
        apply_reset(1, 1, 100, 1'b1);
        repeat (5) @(negedge clk);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h203;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #2;
        check("rc_addr", bus.imem_addr, 32'h200);
        check("rc_valid_n1", bus.instr_valid, 1'b0);
        @(negedge clk);
        #2;
        check("rc_valid_n2", bus.instr_valid, 1'b0);
        @(negedge clk);
        #2;
        check("rc_valid_n3", bus.instr_valid, 1'b1);
        check("rc_pc_n3", bus.instr_pc, 32'h200);

        // Random grant/latency/ready with occasional redirects, one forced on a pop cycle.
        apply_reset(1, 4, 50, 1'b1);
        did_pop_redir = 1'b0;
        p0 = pop_cnt;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            bus.instr_ready    = ($urandom_range(9) < 7);
            bus.redirect_valid = ($urandom_range(24) == 0);
            bus.redirect_pc    = $urandom & 32'h0000_FFFF;
            if (!did_pop_redir && i > 100 && bus.instr_valid) begin
                bus.instr_ready    = 1'b1;
                bus.redirect_valid = 1'b1;
                did_pop_redir      = 1'b1;
            end
        end
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        bus.instr_ready    = 1'b1;
        repeat (20) @(negedge clk);
        #2;
        check("rnd_pop_redir_hit", did_pop_redir, 1'b1);
        check("rnd_progress", (pop_cnt - p0) > 50, 1'b1);

        // Reset mid-stream with a non-empty queue and three requests in flight.
        apply_reset(4, 4, 100, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #2;
        check("mr_req", bus.imem_req, 1'b0);
        check("mr_valid", bus.instr_valid, 1'b0);
        check("mr_instr", bus.instr, 32'h0);
        check("mr_pc", bus.instr_pc, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        lat_min = 1;
        lat_max = 1;
        bus.instr_ready = 1'b1;
        #2;
        check("mr_after_valid", bus.instr_valid, 1'b0);
        check("mr_after_addr", bus.imem_addr, 32'h0);
        check("mr_after_req", bus.imem_req, 1'b1);
        wait_valid("mr_refetch", 10);
        check("mr_refetch_pc", bus.instr_pc, 32'h0);

        // Address wrap past 0xFFFF_FFFC.
        @(negedge clk);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #2;
        wait_valid("wrap_valid", 10);
        check("wrap_pc0", bus.instr_pc, 32'hFFFF_FFFC);
        @(negedge clk);
        #2;
        check("wrap_valid1", bus.instr_valid, 1'b1);
        check("wrap_pc1", bus.instr_pc, 32'h0);
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
